// File: rtl/region_bin_adapt.sv
// Local-mean adaptive binariser: WIN x WIN box sum from WIN-1 line buffers,
// centre compared against mean + offset, 3-cycle pipeline on the sync stream.
module region_bin_adapt #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 1280,
    parameter int WIN    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pre_img_vsync,
    input  logic              pre_img_hsync,
    input  logic              pre_img_valid,
    input  logic [DATA_W-1:0] pre_img_data,
    input  logic [DATA_W-1:0] thr_offset,
    input  logic              mode,
    output logic              post_img_vsync,
    output logic              post_img_hsync,
    output logic              post_img_valid,
    output logic [DATA_W-1:0] post_img_data
);
    localparam int R      = (WIN - 1) / 2;
    localparam int STAGES = 3;
    localparam int WIN2   = WIN * WIN;
    localparam int CSW    = DATA_W + $clog2(WIN);
    localparam int SW     = DATA_W + $clog2(WIN2);
    localparam int CW     = SW + 1;
    localparam int COLW   = $clog2(IMG_W + 1);
    localparam int ROWW   = $clog2(2 * R + 1);
    localparam int AW     = $clog2(IMG_W);

    logic [STAGES:1] vld_pipe, vs_pipe, hs_pipe;
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;
    logic            armed;
    logic [DATA_W-1:0] cfg_off;
    logic            cfg_mode;
    logic            vs_rise, vld_fall, in_rng;
    logic [AW-1:0]   addr;

    assign vs_rise  = pre_img_vsync & ~vs_pipe[1];
    assign vld_fall = ~pre_img_valid & vld_pipe[1];
    assign in_rng   = col < COLW'(IMG_W);
    assign addr     = in_rng ? AW'(col) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            vs_pipe  <= '0;
            hs_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], pre_img_valid};
            vs_pipe  <= {vs_pipe[STAGES-1:1], pre_img_vsync};
            hs_pipe  <= {hs_pipe[STAGES-1:1], pre_img_hsync};
        end
    end

    // armed stays low after reset until a frame start, so a half frame is never shown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            armed    <= 1'b0;
            cfg_off  <= '0;
            cfg_mode <= 1'b0;
        end else begin
            if (vs_rise) begin
                cfg_off  <= thr_offset;
                cfg_mode <= mode;
                armed    <= 1'b1;
            end
            if (vld_fall)
                col <= '0;
            else if (pre_img_valid && in_rng)
                col <= col + 1'b1;
            if (vs_rise)
                row <= '0;
            else if (vld_fall && row != ROWW'(2 * R))
                row <= row + 1'b1;
        end
    end

    logic [DATA_W-1:0] lbuf [WIN-1][IMG_W];

    always_ff @(posedge clk) begin
        if (pre_img_valid && in_rng) begin
            lbuf[0][addr] <= pre_img_data;
            for (int k = 1; k < WIN - 1; k++)
                lbuf[k][addr] <= lbuf[k-1][addr];
        end
    end

    // c0 -> c1: vertical column, element k is the pixel k rows above
    logic [WIN-1:0][DATA_W-1:0] col1;
    logic              mask1, mode1;
    logic [DATA_W-1:0] off1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col1  <= '0;
            mask1 <= 1'b1;
            off1  <= '0;
            mode1 <= 1'b0;
        end else if (pre_img_valid) begin
            col1[0] <= pre_img_data;
            for (int k = 1; k < WIN; k++)
                col1[k] <= lbuf[k-1][addr];
            mask1 <= !armed || !in_rng || (row < ROWW'(2 * R)) || (col < COLW'(2 * R));
            off1  <= cfg_off;
            mode1 <= cfg_mode;
        end
    end

    logic [CSW-1:0] csum;

    always_comb begin
        csum = '0;
        for (int k = 0; k < WIN; k++)
            csum = csum + CSW'(col1[k]);
    end

    // c1 -> c2: S always equals the sum of csr; the modular update is exact
    logic [WIN-1:0][CSW-1:0]  csr;
    logic [R:0][DATA_W-1:0]   ctr_sr;
    logic [SW-1:0]            ssum;
    logic                     mask2, mode2;
    logic [DATA_W-1:0]        off2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr    <= '0;
            ctr_sr <= '0;
            ssum   <= '0;
            mask2  <= 1'b1;
            off2   <= '0;
            mode2  <= 1'b0;
        end else if (vld_pipe[1]) begin
            csr    <= {csr[WIN-2:0], csum};
            ctr_sr <= {ctr_sr[R-1:0], col1[R]};
            ssum   <= ssum + SW'(csum) - SW'(csr[WIN-1]);
            mask2  <= mask1;
            off2   <= off1;
            mode2  <= mode1;
        end
    end

    logic [CW-1:0]     lhs, rhs;
    logic              fg;
    logic [DATA_W-1:0] data_q;

    assign lhs = CW'(ctr_sr[R]) * CW'(WIN2);
    assign rhs = CW'(ssum) + CW'(off2) * CW'(WIN2);
    assign fg  = lhs > rhs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data_q <= '0;
        else
            data_q <= (vld_pipe[2] && !mask2 && (fg ^ mode2)) ? '1 : '0;
    end

    assign post_img_vsync = vs_pipe[STAGES];
    assign post_img_hsync = hs_pipe[STAGES];
    assign post_img_valid = vld_pipe[STAGES];
    assign post_img_data  = data_q;

endmodule

// File: tb/tb_region_bin_adapt.sv
// Bench for region_bin_adapt: frames checked cycle by cycle against a direct
// window-sum reference computed from the whole frame image.
module tb_region_bin_adapt;
    localparam int DW  = 8;
    localparam int IW  = 16;
    localparam int WIN = 5;
    localparam int R   = (WIN - 1) / 2;
    localparam int NL  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b0, hs = 1'b0, vld = 1'b0, md = 1'b0;
    logic [DW-1:0] din = '0, thr = '0;
    logic ovs, ohs, ovld;
    logic [DW-1:0] odata;

    region_bin_adapt #(.DATA_W(DW), .IMG_W(IW), .WIN(WIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .pre_img_vsync(vs), .pre_img_hsync(hs), .pre_img_valid(vld), .pre_img_data(din),
        .thr_offset(thr), .mode(md),
        .post_img_vsync(ovs), .post_img_hsync(ohs), .post_img_valid(ovld), .post_img_data(odata)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, ff_cnt = 0;
    logic [DW-1:0] img [NL][IW];
    int f_off;
    bit f_md;
    logic [DW+2:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // expected output at input position (r,c): decision for centre (r-R, c-R)
    function automatic logic [DW-1:0] model(input int r, input int c);
        int s, ctr;
        if (r < 2 * R || c < 2 * R || c >= IW) return '0;
        s = 0;
        for (int dr = 0; dr < WIN; dr++)
            for (int dc = 0; dc < WIN; dc++)
                s += int'(img[r-dr][c-dc]);
        ctr = int'(img[r-R][c-R]);
        return ((ctr * WIN * WIN > s + f_off * WIN * WIN) ^ f_md) ? '1 : '0;
    endfunction

    task automatic step(input logic v, input logic h, input logic d,
                        input logic [DW-1:0] px, input logic [DW-1:0] e);
        vs = v; hs = h; vld = d; din = px;
        @(posedge clk);
        exp_q.push_back({v, h, d, e});
        #1;
        if (odata == '1) ff_cnt++;
        chk("stream", {21'd0, ovs, ohs, ovld, odata}, {21'd0, exp_q.pop_front()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic mid_reset();
        vs = 1'b0; hs = 1'b0; vld = 1'b0; din = '0;
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {21'd0, ovs, ohs, ovld, odata}, 32'd0);
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        idle(3);
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic frame(input int gap_max, input int extra_max,
                         input int chg_row, input logic [DW-1:0] chg_off, input int rst_row);
        int n_ext, n_gap;
        f_off = int'(thr);
        f_md  = md;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        idle(2);
        for (int r = 0; r < NL; r++) begin
            if (r == chg_row) thr = chg_off;
            step(1'b0, 1'b1, 1'b0, '0, '0);
            for (int c = 0; c < IW; c++) begin
                if (r == rst_row && c == 7) begin
                    mid_reset();
                    return;
                end
                step(1'b0, 1'b1, 1'b1, img[r][c], model(r, c));
            end
            n_ext = $urandom_range(extra_max, 0);
            for (int c = IW; c < IW + n_ext; c++)
                step(1'b0, 1'b1, 1'b1, DW'($urandom), model(r, c));
            n_gap = $urandom_range(gap_max, 1);
            idle(n_gap);
        end
        idle(3);
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int r = 0; r < NL; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = v;
    endtask

    initial begin
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1 chk("reset", {21'd0, ovs, ohs, ovld, odata}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(3);

        fill(8'h80); thr = '0; md = 1'b0; ff_cnt = 0;
        frame(3, 0, -1, '0, -1);
        chk("flat_m0_ones", ff_cnt, 0);

        md = 1'b1; ff_cnt = 0;
        frame(3, 0, -1, '0, -1);
        chk("flat_m1_ones", ff_cnt, (NL - 2 * R) * (IW - 2 * R));

        fill(8'h10); img[10][10] = 8'hFF; md = 1'b0; ff_cnt = 0;
        frame(4, 0, -1, '0, -1);
        chk("impulse_ones", ff_cnt, 1);

        for (int r = 0; r < NL; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = (c < IW / 2) ? 8'h20 : 8'h60;
        thr = '0; ff_cnt = 0;
        frame(3, 0, 6, 8'h50, -1);
        chk("ofs_f1_ones", ff_cnt, 2 * (NL - 2 * R));
        ff_cnt = 0;
        frame(3, 0, -1, '0, -1);
        chk("ofs_f2_ones", ff_cnt, 0);

        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < NL; r++)
                for (int c = 0; c < IW; c++)
                    img[r][c] = DW'($urandom);
            thr = DW'($urandom_range(15, 0));
            md  = 1'($urandom_range(1, 0));
            frame(6, 3, -1, '0, -1);
        end

        fill(8'h80); thr = '0; md = 1'b1;
        frame(3, 0, -1, '0, 8);
        ff_cnt = 0;
        frame(3, 0, -1, '0, -1);
        chk("post_rst_ones", ff_cnt, (NL - 2 * R) * (IW - 2 * R));

        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
